// File: rtl/uart_receiver_cfg_if.sv
// Output side of the UART receiver: received word, status flags and the
// consumer handshake that drains the holding register.
interface uart_receiver_cfg_if #(
  parameter int DATA_BITS = 8
);
  // Handshake: the word in dout is taken on any rising clk edge where
  // dout_valid and dout_ready are both 1; dout_valid never waits on dout_ready.
  logic [DATA_BITS-1:0] dout;
  logic                 dout_valid;
  logic                 dout_ready;
  logic                 rx_done;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun_err;

  modport master (
    output dout,
    output dout_valid,
    input  dout_ready,
    output rx_done,
    output parity_err,
    output frame_err,
    output overrun_err
  );

  modport slave (
    input  dout,
    input  dout_valid,
    output dout_ready,
    input  rx_done,
    input  parity_err,
    input  frame_err,
    input  overrun_err
  );
endinterface

// File: rtl/uart_receiver_cfg.sv
// Oversampling UART receiver with configurable frame format and a single-word
// holding register that is overwritten (with an overrun pulse) when not drained.
module uart_receiver_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_tick,
  input  logic               rx,
  output logic [2:0]         fsm_state,
  uart_receiver_cfg_if.master bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam int           TW        = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]   BIT_LAST  = 4'(DATA_BITS - 1);
  localparam logic [3:0]   STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic         HAS_PAR   = (PARITY_EN != 0);
  localparam logic         PAR_ODD   = (PARITY_ODD != 0);

  state_t               state, state_n;
  logic                 rx_meta, rx_s, rx_prev;
  logic [TW-1:0]        tick_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bad, stop_bad;

  logic                 rx_done_r, valid_r, perr_r, ferr_r;
  logic [DATA_BITS-1:0] dout_r;

  logic tick_clr, tick_inc, bit_clr, bit_inc;
  logic shift_en, par_en, stop_en, start_frame, frame_end;
  logic at_half, at_last;

  assign at_half = s_tick && (tick_cnt == TICK_HALF);
  assign at_last = s_tick && (tick_cnt == TICK_LAST);

  // Two-flop synchroniser; rx_prev gives the falling-edge detect that keeps a
  // held-low line (break) from re-arming the receiver.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n     = state;
    tick_clr    = 1'b0;
    tick_inc    = 1'b0;
    bit_clr     = 1'b0;
    bit_inc     = 1'b0;
    shift_en    = 1'b0;
    par_en      = 1'b0;
    stop_en     = 1'b0;
    start_frame = 1'b0;
    frame_end   = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s && rx_prev) begin
          state_n     = START;
          tick_clr    = 1'b1;
          start_frame = 1'b1;
        end
      end
      START: begin
        if (at_half) begin
          tick_clr = 1'b1;
          bit_clr  = 1'b1;
          state_n  = rx_s ? IDLE : DATA;
        end else begin
          tick_inc = s_tick;
        end
      end
      DATA: begin
        if (at_last) begin
          tick_clr = 1'b1;
          shift_en = 1'b1;
          if (bit_cnt == BIT_LAST) begin
            bit_clr = 1'b1;
            state_n = HAS_PAR ? PARITY : STOP;
          end else begin
            bit_inc = 1'b1;
          end
        end else begin
          tick_inc = s_tick;
        end
      end
      PARITY: begin
        if (at_last) begin
          tick_clr = 1'b1;
          par_en   = 1'b1;
          bit_clr  = 1'b1;
          state_n  = STOP;
        end else begin
          tick_inc = s_tick;
        end
      end
      STOP: begin
        if (at_last) begin
          tick_clr = 1'b1;
          stop_en  = 1'b1;
          if (bit_cnt == STOP_LAST) begin
            bit_clr   = 1'b1;
            frame_end = 1'b1;
            state_n   = IDLE;
          end else begin
            bit_inc = 1'b1;
          end
        end else begin
          tick_inc = s_tick;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bad  <= 1'b0;
      stop_bad <= 1'b0;
    end else begin
      if (tick_clr)      tick_cnt <= '0;
      else if (tick_inc) tick_cnt <= tick_cnt + 1'b1;

      if (bit_clr)      bit_cnt <= '0;
      else if (bit_inc) bit_cnt <= bit_cnt + 1'b1;

      // LSB arrives first, so new bits enter at the top and shift down.
      if (shift_en) shreg <= {rx_s, shreg[DATA_BITS-1:1]};

      if (start_frame) begin
        par_bad  <= 1'b0;
        stop_bad <= 1'b0;
      end else begin
        if (par_en)  par_bad  <= ((^shreg) ^ rx_s) != PAR_ODD;
        if (stop_en) stop_bad <= stop_bad | ~rx_s;
      end
    end
  end

  // rx_done marks the cycle in which the finished frame is written into the
  // holding register; the write lands on the edge that ends that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_done_r <= 1'b0;
      valid_r   <= 1'b0;
      dout_r    <= '0;
      perr_r    <= 1'b0;
      ferr_r    <= 1'b0;
    end else begin
      rx_done_r <= frame_end;
      if (rx_done_r) begin
        dout_r  <= shreg;
        perr_r  <= par_bad;
        ferr_r  <= stop_bad;
        valid_r <= 1'b1;
      end else if (valid_r && bus.dout_ready) begin
        valid_r <= 1'b0;
      end
    end
  end

  assign bus.dout        = dout_r;
  assign bus.dout_valid  = valid_r;
  assign bus.rx_done     = rx_done_r;
  assign bus.parity_err  = perr_r;
  assign bus.frame_err   = ferr_r;
  assign bus.overrun_err = rx_done_r & valid_r & ~bus.dout_ready;
  assign fsm_state       = state;

endmodule

// File: tb/tb_uart_receiver_cfg.sv
// Directed bench for uart_receiver_cfg across four frame formats, checking
// delivered words, error flags, overrun behaviour, glitch/break and reset.
module tb_uart_receiver_cfg;

  logic clk, rst, s_tick;
  logic rx_def, rx_par, rx_s2, rx_nine;
  logic [2:0] st_def, st_par, st_s2, st_nine;

  int n_checks = 0;
  int n_fail   = 0;
  int done_def = 0, done_par = 0, done_s2 = 0, done_nine = 0;
  int ovr_def  = 0;

  uart_receiver_cfg_if #(.DATA_BITS(8)) bus_def ();
  uart_receiver_cfg_if #(.DATA_BITS(8)) bus_par ();
  uart_receiver_cfg_if #(.DATA_BITS(8)) bus_s2 ();
  uart_receiver_cfg_if #(.DATA_BITS(9)) bus_nine ();

  uart_receiver_cfg u_def (
    .clk(clk), .rst(rst), .s_tick(s_tick), .rx(rx_def), .fsm_state(st_def), .bus(bus_def));
  uart_receiver_cfg #(.PARITY_EN(1), .PARITY_ODD(0)) u_par (
    .clk(clk), .rst(rst), .s_tick(s_tick), .rx(rx_par), .fsm_state(st_par), .bus(bus_par));
  uart_receiver_cfg #(.STOP_BITS(2)) u_s2 (
    .clk(clk), .rst(rst), .s_tick(s_tick), .rx(rx_s2), .fsm_state(st_s2), .bus(bus_s2));
  uart_receiver_cfg #(.DATA_BITS(9), .OVERSAMPLE(8)) u_nine (
    .clk(clk), .rst(rst), .s_tick(s_tick), .rx(rx_nine), .fsm_state(st_nine), .bus(bus_nine));

  // clock / reset / baud tick
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    s_tick = 1'b0;
    forever begin
      @(negedge clk);
      s_tick = ~s_tick;
    end
  end

  // pulse monitor, sampled after the negedge drivers have settled
  always @(negedge clk) begin
    #2;
    if (bus_def.rx_done === 1'b1)  done_def++;
    if (bus_par.rx_done === 1'b1)  done_par++;
    if (bus_s2.rx_done === 1'b1)   done_s2++;
    if (bus_nine.rx_done === 1'b1) done_nine++;
    if (bus_def.overrun_err === 1'b1 && bus_def.rx_done === 1'b1) ovr_def++;
  end

  // driver tasks
  task automatic set_rx(input int inst, input logic v);
    case (inst)
      0:       rx_def = v;
      1:       rx_par = v;
      2:       rx_s2 = v;
      default: rx_nine = v;
    endcase
  endtask

  task automatic send_frame(input int inst, input logic [8:0] data, input logic pbit,
                            input logic [1:0] stops);
    int nb, bp, pe, ns;
    case (inst)
      0:       begin nb = 8; bp = 32; pe = 0; ns = 1; end
      1:       begin nb = 8; bp = 32; pe = 1; ns = 1; end
      2:       begin nb = 8; bp = 32; pe = 0; ns = 2; end
      default: begin nb = 9; bp = 16; pe = 0; ns = 1; end
    endcase
    set_rx(inst, 1'b0);
    repeat (bp) @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      set_rx(inst, data[i]);
      repeat (bp) @(negedge clk);
    end
    if (pe != 0) begin
      set_rx(inst, pbit);
      repeat (bp) @(negedge clk);
    end
    for (int i = 0; i < ns; i++) begin
      set_rx(inst, stops[i]);
      repeat (bp) @(negedge clk);
    end
    set_rx(inst, 1'b1);
    repeat (4) @(negedge clk);
  endtask

  task automatic consume_def();
    bus_def.dout_ready = 1'b1;
    @(negedge clk);
    bus_def.dout_ready = 1'b0;
    @(negedge clk);
  endtask

  // scenarios
  task automatic test_reset();
    n_checks++;
    if (bus_def.dout !== 8'h00 || bus_def.dout_valid !== 1'b0 || bus_def.rx_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_def_out: dout=%h valid=%b done=%b, want 00/0/0",
               bus_def.dout, bus_def.dout_valid, bus_def.rx_done);
    end
    n_checks++;
    if (bus_def.parity_err !== 1'b0 || bus_def.frame_err !== 1'b0 || bus_def.overrun_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_def_err: perr=%b ferr=%b ovr=%b, want 0/0/0",
               bus_def.parity_err, bus_def.frame_err, bus_def.overrun_err);
    end
    n_checks++;
    if (st_def !== 3'd0 || st_par !== 3'd0 || st_s2 !== 3'd0 || st_nine !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_state: %0d %0d %0d %0d, want all 0", st_def, st_par, st_s2, st_nine);
    end
    n_checks++;
    if (bus_nine.dout !== 9'h000 || bus_nine.dout_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_nine: dout=%h valid=%b, want 000/0", bus_nine.dout, bus_nine.dout_valid);
    end
  endtask

  task automatic test_basic();
    int d0 = done_def;
    send_frame(0, 9'h055, 1'b0, 2'b11);
    n_checks++;
    if (done_def - d0 != 1) begin
      n_fail++;
      $display("FAIL basic_done_count: got %0d, want 1", done_def - d0);
    end
    n_checks++;
    if (bus_def.dout !== 8'h55 || bus_def.dout_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_word: dout=%h valid=%b, want 55/1", bus_def.dout, bus_def.dout_valid);
    end
    n_checks++;
    if (bus_def.parity_err !== 1'b0 || bus_def.frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_flags: perr=%b ferr=%b, want 0/0", bus_def.parity_err, bus_def.frame_err);
    end
    consume_def();
    n_checks++;
    if (bus_def.dout_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_consume: valid=%b, want 0", bus_def.dout_valid);
    end
  endtask

  task automatic test_parity();
    int d0 = done_par;
    send_frame(1, 9'h007, 1'b0, 2'b11);
    n_checks++;
    if (bus_par.dout !== 8'h07 || bus_par.parity_err !== 1'b1 || bus_par.frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL parity_bad: dout=%h perr=%b ferr=%b, want 07/1/0",
               bus_par.dout, bus_par.parity_err, bus_par.frame_err);
    end
    send_frame(1, 9'h007, 1'b1, 2'b11);
    n_checks++;
    if (bus_par.dout !== 8'h07 || bus_par.parity_err !== 1'b0) begin
      n_fail++;
      $display("FAIL parity_good: dout=%h perr=%b, want 07/0", bus_par.dout, bus_par.parity_err);
    end
    n_checks++;
    if (done_par - d0 != 2) begin
      n_fail++;
      $display("FAIL parity_done_count: got %0d, want 2", done_par - d0);
    end
  endtask

  task automatic test_frame_err();
    send_frame(0, 9'h0A3, 1'b0, 2'b00);
    n_checks++;
    if (bus_def.dout !== 8'hA3 || bus_def.frame_err !== 1'b1 || bus_def.dout_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_err_stop0: dout=%h ferr=%b valid=%b, want A3/1/1",
               bus_def.dout, bus_def.frame_err, bus_def.dout_valid);
    end
    send_frame(2, 9'h05A, 1'b0, 2'b11);
    n_checks++;
    if (bus_s2.dout !== 8'h5A || bus_s2.frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL stop2_good: dout=%h ferr=%b, want 5A/0", bus_s2.dout, bus_s2.frame_err);
    end
    send_frame(2, 9'h0C3, 1'b0, 2'b01);
    n_checks++;
    if (bus_s2.dout !== 8'hC3 || bus_s2.frame_err !== 1'b1) begin
      n_fail++;
      $display("FAIL stop2_second_low: dout=%h ferr=%b, want C3/1", bus_s2.dout, bus_s2.frame_err);
    end
    n_checks++;
    if (done_s2 != 2) begin
      n_fail++;
      $display("FAIL stop2_done_count: got %0d, want 2", done_s2);
    end
  endtask

  task automatic test_glitch();
    int d0 = done_def;
    rx_def = 1'b0;
    repeat (6) @(negedge clk);
    rx_def = 1'b1;
    repeat (60) @(negedge clk);
    n_checks++;
    if (done_def != d0 || st_def !== 3'd0) begin
      n_fail++;
      $display("FAIL glitch_ignored: done_delta=%0d state=%0d, want 0/0", done_def - d0, st_def);
    end
    n_checks++;
    if (bus_def.dout_valid !== 1'b1 || bus_def.dout !== 8'hA3) begin
      n_fail++;
      $display("FAIL glitch_hold: valid=%b dout=%h, want 1/A3", bus_def.dout_valid, bus_def.dout);
    end
  endtask

  task automatic test_back_to_back();
    int o0;
    bit found;
    consume_def();
    o0 = ovr_def;
    send_frame(0, 9'h011, 1'b0, 2'b11);
    send_frame(0, 9'h022, 1'b0, 2'b11);
    n_checks++;
    if (ovr_def - o0 != 1) begin
      n_fail++;
      $display("FAIL overrun_count: got %0d, want 1", ovr_def - o0);
    end
    n_checks++;
    if (bus_def.dout !== 8'h22 || bus_def.dout_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_word: dout=%h valid=%b, want 22/1", bus_def.dout, bus_def.dout_valid);
    end
    consume_def();
    send_frame(0, 9'h011, 1'b0, 2'b11);
    o0 = ovr_def;
    found = 1'b0;
    fork
      send_frame(0, 9'h022, 1'b0, 2'b11);
      begin
        for (int k = 0; k < 2000 && !found; k++) begin
          @(negedge clk);
          if (bus_def.rx_done === 1'b1) begin
            found = 1'b1;
            bus_def.dout_ready = 1'b1;
            #1;
            n_checks++;
            if (bus_def.overrun_err !== 1'b0) begin
              n_fail++;
              $display("FAIL handshake_no_overrun: ovr=%b, want 0", bus_def.overrun_err);
            end
            @(negedge clk);
            bus_def.dout_ready = 1'b0;
          end
        end
      end
    join
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL handshake_rx_done_timeout: rx_done seen=0, want 1");
    end
    n_checks++;
    if (bus_def.dout !== 8'h22 || bus_def.dout_valid !== 1'b1 || ovr_def != o0) begin
      n_fail++;
      $display("FAIL handshake_word: dout=%h valid=%b ovr_delta=%0d, want 22/1/0",
               bus_def.dout, bus_def.dout_valid, ovr_def - o0);
    end
  endtask

  task automatic test_break();
    int d0;
    consume_def();
    d0 = done_def;
    rx_def = 1'b0;
    repeat (12 * 32) @(negedge clk);
    n_checks++;
    if (done_def - d0 != 1 || bus_def.dout !== 8'h00 || bus_def.frame_err !== 1'b1) begin
      n_fail++;
      $display("FAIL break_frame: done_delta=%0d dout=%h ferr=%b, want 1/00/1",
               done_def - d0, bus_def.dout, bus_def.frame_err);
    end
    n_checks++;
    if (st_def !== 3'd0) begin
      n_fail++;
      $display("FAIL break_no_rearm: state=%0d, want 0", st_def);
    end
    rx_def = 1'b1;
    repeat (64) @(negedge clk);
    send_frame(0, 9'h03C, 1'b0, 2'b11);
    n_checks++;
    if (done_def - d0 != 2 || bus_def.dout !== 8'h3C || bus_def.frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL break_recover: done_delta=%0d dout=%h ferr=%b, want 2/3C/0",
               done_def - d0, bus_def.dout, bus_def.frame_err);
    end
  endtask

  task automatic test_nine_and_reset();
    int d0 = done_nine;
    send_frame(3, 9'h1F0, 1'b0, 2'b11);
    n_checks++;
    if (bus_nine.dout !== 9'h1F0 || bus_nine.dout_valid !== 1'b1 || done_nine - d0 != 1) begin
      n_fail++;
      $display("FAIL nine_word: dout=%h valid=%b done_delta=%0d, want 1F0/1/1",
               bus_nine.dout, bus_nine.dout_valid, done_nine - d0);
    end
    d0 = done_nine;
    rx_nine = 1'b0;
    repeat (16) @(negedge clk);
    rx_nine = 1'b1;
    repeat (16) @(negedge clk);
    rx_nine = 1'b0;
    repeat (24) @(negedge clk);
    n_checks++;
    if (st_nine !== 3'd2) begin
      n_fail++;
      $display("FAIL nine_in_data: state=%0d, want 2", st_nine);
    end
    rst = 1'b1;
    rx_nine = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    n_checks++;
    if (done_nine != d0 || st_nine !== 3'd0 || bus_nine.dout_valid !== 1'b0 || bus_nine.dout !== 9'h000) begin
      n_fail++;
      $display("FAIL nine_reset_abort: done_delta=%0d state=%0d valid=%b dout=%h, want 0/0/0/000",
               done_nine - d0, st_nine, bus_nine.dout_valid, bus_nine.dout);
    end
    send_frame(3, 9'h0AB, 1'b0, 2'b11);
    n_checks++;
    if (bus_nine.dout !== 9'h0AB || bus_nine.frame_err !== 1'b0 || done_nine - d0 != 1) begin
      n_fail++;
      $display("FAIL nine_after_reset: dout=%h ferr=%b done_delta=%0d, want 0AB/0/1",
               bus_nine.dout, bus_nine.frame_err, done_nine - d0);
    end
  endtask

  initial begin
    rst = 1'b1;
    rx_def = 1'b1; rx_par = 1'b1; rx_s2 = 1'b1; rx_nine = 1'b1;
    bus_def.dout_ready = 1'b0;
    bus_par.dout_ready = 1'b0;
    bus_s2.dout_ready = 1'b0;
    bus_nine.dout_ready = 1'b0;
    repeat (4) @(negedge clk);
    test_reset();
    rst = 1'b0;
    repeat (8) @(negedge clk);
    test_basic();
    test_parity();
    test_frame_err();
    test_glitch();
    test_back_to_back();
    test_break();
    test_nine_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
